// File: rtl/snake_pkg.sv
// Shared constants, build-FSM encoding and tile geometry helper for the snake overlay.
package snake_pkg;

    localparam logic [11:0] HEAD_COLOR_DEF = 12'h0F0;
    localparam logic [11:0] BODY_COLOR_DEF = 12'h080;
    localparam logic [11:0] FOOD_COLOR_DEF = 12'hF00;
    localparam logic [11:0] DEAD_COLOR_DEF = 12'h888;

    localparam int unsigned GRID_COLS_DEF = 10;
    localparam int unsigned GRID_ROWS_DEF = 10;
    localparam int unsigned TILE_SIZE_DEF = 40;
    localparam int unsigned BOARD_X0_DEF  = 48;
    localparam int unsigned BOARD_Y0_DEF  = 48;

    typedef enum logic [1:0] {StIdle, StClear, StScan, StCommit} build_state_e;

    // Counts constant tile boundaries at or left of coord; boundaries are accumulated, not multiplied.
    function automatic int unsigned tile_of(input logic [31:0] coord, input int unsigned origin,
                                            input int unsigned tile, input int unsigned count);
        int unsigned n;
        int unsigned b;
        n = 0;
        b = origin;
        for (int unsigned k = 1; k < count; k++) begin
            b = b + tile;
            if (coord >= b) n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/snake_tile_index.sv
// Pixel coordinate to tile index via a chain of compares against constant boundaries.
module snake_tile_index
    import snake_pkg::*;
#(
    parameter int unsigned ORIGIN = BOARD_X0_DEF,
    parameter int unsigned TILE   = TILE_SIZE_DEF,
    parameter int unsigned COUNT  = GRID_COLS_DEF,
    parameter int unsigned IDX_W  = 4
) (
    input  logic [31:0]      i_coord,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_on_board
);

    localparam int unsigned LIMIT = ORIGIN + COUNT * TILE;

    assign o_idx      = IDX_W'(tile_of(i_coord, ORIGIN, TILE, COUNT));
    assign o_on_board = (i_coord >= ORIGIN) && (i_coord < LIMIT);

endmodule

// File: rtl/snake_tile_renderer.sv
// Per-frame snake bitmap builder with atomic commit, plus a registered tile-colour pixel overlay.
module snake_tile_renderer
    import snake_pkg::*;
#(
    parameter int unsigned MAX_SEGMENTS = 100,
    parameter int unsigned COORD_W      = 32,
    parameter int unsigned GRID_COLS    = GRID_COLS_DEF,
    parameter int unsigned GRID_ROWS    = GRID_ROWS_DEF,
    parameter int unsigned TILE_SIZE    = TILE_SIZE_DEF,
    parameter int unsigned BOARD_X0     = BOARD_X0_DEF,
    parameter int unsigned BOARD_Y0     = BOARD_Y0_DEF,
    parameter logic [11:0] HEAD_COLOR   = HEAD_COLOR_DEF,
    parameter logic [11:0] BODY_COLOR   = BODY_COLOR_DEF,
    parameter logic [11:0] FOOD_COLOR   = FOOD_COLOR_DEF,
    parameter logic [11:0] DEAD_COLOR   = DEAD_COLOR_DEF,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic                              clk25,
    input  logic                              reset,
    input  logic [MAX_SEGMENTS*COORD_W-1:0]   x_values,
    input  logic [MAX_SEGMENTS*COORD_W-1:0]   y_values,
    input  logic [$clog2(MAX_SEGMENTS+1)-1:0] snake_len,
    input  logic [COORD_W-1:0]                food_x,
    input  logic [COORD_W-1:0]                food_y,
    input  logic                              food_valid,
    input  logic                              game_done,
    input  logic                              screenEnd,
    input  logic                              active,
    input  logic [31:0]                       x,
    input  logic [31:0]                       y,
    input  logic [11:0]                       bg_color,
    output logic [11:0]                       color_out,
    output logic                              build_busy,
    output logic                              seg_error
);

    localparam int unsigned LEN_W   = $clog2(MAX_SEGMENTS + 1);
    localparam int unsigned COL_W   = $clog2(GRID_COLS + 1);
    localparam int unsigned ROW_W   = $clog2(GRID_ROWS + 1);
    localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);

    build_state_e r_state, w_state_next;

    logic [GRID_ROWS-1:0][GRID_COLS-1:0] r_shadow, r_disp;
    logic [COL_W-1:0]   r_shadow_head_col, r_disp_head_col;
    logic [ROW_W-1:0]   r_shadow_head_row, r_disp_head_row;
    logic               r_shadow_head_valid, r_disp_head_valid;
    logic               r_shadow_err, r_seg_error;
    logic [LEN_W-1:0]   r_len, r_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [11:0]        r_color;

    logic [LEN_W-1:0]   w_len_clamped;
    logic [COORD_W-1:0] w_seg_x, w_seg_y;
    logic               w_seg_on;

    assign w_len_clamped = (snake_len > LEN_W'(MAX_SEGMENTS)) ? LEN_W'(MAX_SEGMENTS) : snake_len;
    assign w_seg_x  = x_values[r_idx*COORD_W +: COORD_W];
    assign w_seg_y  = y_values[r_idx*COORD_W +: COORD_W];
    assign w_seg_on = (w_seg_x < COORD_W'(GRID_COLS)) && (w_seg_y < COORD_W'(GRID_ROWS));

    always_ff @(posedge clk25) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        build_busy   = (r_state != StIdle);
        unique case (r_state)
            StIdle:   if (screenEnd) w_state_next = StClear;
            StClear:  w_state_next = (w_len_clamped == '0) ? StCommit : StScan;
            StScan:   if (r_idx == r_len - LEN_W'(1)) w_state_next = StCommit;
            StCommit: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            r_shadow            <= '0;
            r_disp              <= '0;
            r_shadow_head_col   <= '0;
            r_shadow_head_row   <= '0;
            r_disp_head_col     <= '0;
            r_disp_head_row     <= '0;
            r_shadow_head_valid <= 1'b0;
            r_disp_head_valid   <= 1'b0;
            r_shadow_err        <= 1'b0;
            r_seg_error         <= 1'b0;
            r_len               <= '0;
            r_idx               <= '0;
            r_blink_cnt         <= '0;
            r_blink_phase       <= 1'b0;
        end else begin
            unique case (r_state)
                StClear: begin
                    r_shadow            <= '0;
                    r_shadow_err        <= 1'b0;
                    r_shadow_head_valid <= 1'b0;
                    r_len               <= w_len_clamped;
                    r_idx               <= '0;
                end
                StScan: begin
                    r_idx <= r_idx + LEN_W'(1);
                    if (w_seg_on) begin
                        r_shadow[w_seg_y[ROW_W-1:0]][w_seg_x[COL_W-1:0]] <= 1'b1;
                        if (r_idx == '0) begin
                            r_shadow_head_col   <= w_seg_x[COL_W-1:0];
                            r_shadow_head_row   <= w_seg_y[ROW_W-1:0];
                            r_shadow_head_valid <= 1'b1;
                        end
                    end else begin
                        r_shadow_err <= 1'b1;
                    end
                end
                StCommit: begin
                    r_disp            <= r_shadow;
                    r_disp_head_col   <= r_shadow_head_col;
                    r_disp_head_row   <= r_shadow_head_row;
                    r_disp_head_valid <= r_shadow_head_valid;
                    r_seg_error       <= r_shadow_err;
                    // Frame counter kept as (count mod BLINK_FRAMES, parity of quotient).
                    if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                        r_blink_cnt   <= '0;
                        r_blink_phase <= ~r_blink_phase;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_col_on, w_row_on, w_on;
    logic             w_head_hit, w_body_hit, w_food_hit, w_snake_show;
    logic [11:0]      w_color_next;

    snake_tile_index #(
        .ORIGIN(BOARD_X0), .TILE(TILE_SIZE), .COUNT(GRID_COLS), .IDX_W(COL_W)
    ) u_col_index (
        .i_coord(x), .o_idx(w_col), .o_on_board(w_col_on)
    );

    snake_tile_index #(
        .ORIGIN(BOARD_Y0), .TILE(TILE_SIZE), .COUNT(GRID_ROWS), .IDX_W(ROW_W)
    ) u_row_index (
        .i_coord(y), .o_idx(w_row), .o_on_board(w_row_on)
    );

    assign w_on         = w_col_on && w_row_on;
    assign w_head_hit   = r_disp_head_valid && w_on && (w_col == r_disp_head_col)
                          && (w_row == r_disp_head_row);
    assign w_body_hit   = w_on && r_disp[w_row][w_col];
    assign w_food_hit   = food_valid && w_on && (food_x == COORD_W'(w_col))
                          && (food_y == COORD_W'(w_row));
    assign w_snake_show = !(game_done && r_blink_phase);

    always_comb begin
        w_color_next = bg_color;
        if (!active) begin
            w_color_next = 12'h000;
        end else if ((w_head_hit || w_body_hit) && w_snake_show) begin
            if (game_done)       w_color_next = DEAD_COLOR;
            else if (w_head_hit) w_color_next = HEAD_COLOR;
            else                 w_color_next = BODY_COLOR;
        end else if (w_food_hit) begin
            w_color_next = FOOD_COLOR;
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) r_color <= 12'h000;
        else       r_color <= w_color_next;
    end

    assign color_out = r_color;
    assign seg_error = r_seg_error;

endmodule

// File: doc/snake_tile_renderer.md
# snake_tile_renderer

Parametrised multi-segment snake overlay for the VGA path. Once per frame, on `screenEnd`, it walks the snake segment list one segment per cycle and builds a tile-occupancy bitmap, then commits it atomically for the next frame. During the active scan it maps each pixel to a tile and overlays head, body, food or background colour, with a blinking death mode. It sits between the timing generator / palette RAMs and the `VGA_R/G/B` outputs.

## Interface
- `MAX_SEGMENTS`, 100: segment slots on the coordinate buses.
- `COORD_W`, 32: width of one tile coordinate.
- `GRID_COLS`, 10: board width in tiles.
- `GRID_ROWS`, 10: board height in tiles.
- `TILE_SIZE`, 40: tile edge in pixels.
- `BOARD_X0`, 48: left pixel of tile column 0.
- `BOARD_Y0`, 48: top pixel of tile row 0.
- `HEAD_COLOR`, 12'h0F0: head tile colour.
- `BODY_COLOR`, 12'h080: body tile colour.
- `FOOD_COLOR`, 12'hF00: food tile colour.
- `DEAD_COLOR`, 12'h888: snake colour while `game_done`.
- `BLINK_FRAMES`, 16: frames per blink phase in death mode.
- `clk25` in 1: pixel clock. One clock domain only.
- `reset` in 1: synchronous, active-high.
- `x_values` in `MAX_SEGMENTS*COORD_W`: segment column; slot i at `[i*COORD_W +: COORD_W]`; slot 0 is the head.
- `y_values` in `MAX_SEGMENTS*COORD_W`: segment row, same packing.
- `snake_len` in `$clog2(MAX_SEGMENTS+1)`: number of valid segments.
- `food_x`, `food_y` in `COORD_W`: food tile.
- `food_valid` in 1: food drawn when 1.
- `game_done` in 1: death mode.
- `screenEnd` in 1: one-cycle frame boundary pulse.
- `active` in 1: pixel in visible area.
- `x`, `y` in 32: current pixel.
- `bg_color` in 12: background colour, aligned with `x`/`y`.
- `color_out` out 12: `{R,G,B}` to the pins.
- `build_busy` out 1: bitmap build in progress.
- `seg_error` out 1: last build saw an off-board segment.

## Operation
- Build FSM: IDLE → CLEAR → SCAN → COMMIT → IDLE.
  - IDLE: on `screenEnd`, go to CLEAR.
  - CLEAR: zero the shadow bitmap (`GRID_COLS*GRID_ROWS` bits) and the error flag. Latch `len = min(snake_len, MAX_SEGMENTS)`. Clear index i.
  - SCAN: one segment per cycle, slot i.
    - If the segment is on the board, set its shadow bit.
    - If i==0, also latch the head tile and set head-valid.
    - If the segment is off the board (column ≥ `GRID_COLS` or row ≥ `GRID_ROWS`), skip it and set the error flag.
    - Go to COMMIT after slot len-1. If len==0, go straight from CLEAR to COMMIT with head-valid=0.
  - COMMIT: copy shadow bitmap, head tile/valid and error flag to the display registers. Increment the frame counter. Return to IDLE.
- `screenEnd` outside IDLE is ignored.
- Producers must hold the buses stable from `screenEnd` through COMMIT.
- Pixel path (uses display registers only):
  - Tile column = count of constant boundaries `BOARD_X0 + k*TILE_SIZE ≤ x`, for k=1..GRID_COLS-1. Tile row is computed the same way from `y`.
  - No dividers or multipliers on the pixel path.
  - On-board when `BOARD_X0 ≤ x < BOARD_X0+GRID_COLS*TILE_SIZE`, and likewise for y.
- Colour priority: !active → 0; head tile → head; body bit → body; food → `FOOD_COLOR`; else `bg_color`.
- A body bit on the head tile still draws head.
- Death mode: snake (head and body) uses `DEAD_COLOR`. It is hidden (falls through to food/bg) when `frame_cnt / BLINK_FRAMES` is odd.

## Timing
- Reset values:
  - FSM in IDLE; both bitmaps 0; head-valid 0; frame counter 0.
  - `color_out`=0, `build_busy`=0, `seg_error`=0.
- Build latency: `screenEnd` at cycle t → CLEAR t+1, SCAN t+2…t+1+len, COMMIT t+2+len.
- New image visible from cycle t+3+len.
- `build_busy` is high in CLEAR/SCAN/COMMIT.
- `seg_error` updates only at COMMIT.
- Pixel latency is 1 cycle, fully registered: `color_out` at t+1 reflects `x`, `y`, `active`, `bg_color` at t.
- Reset mid-build aborts the build. The display bitmap returns to 0 (blank snake) until the next full build.
- `snake_len > MAX_SEGMENTS` is clamped; no error is flagged.

## Structure
- Shared package `snake_pkg`:
  - colour constants;
  - FSM state encoding;
  - grid and tile geometry defaults;
  - `tile_of` boundary-compare helper function.
- One sub-module `snake_tile_index`: parametrised pixel→tile comparator chain, instantiated for x and y.

## Test plan
- After reset: `active`=1, `bg_color`=12'h123 → `color_out`=12'h123. Pulse `screenEnd` with len=0 → still background, `build_busy` high for exactly 2 cycles.
- len=3, segments (2,2),(3,2),(4,2): pulse `screenEnd` → `build_busy` high 5 cycles.
  - Then pixel (48+2*40, 48+2*40) → HEAD_COLOR.
  - Pixel (48+3*40+39, 128) → BODY_COLOR.
  - Pixel (48+5*40, 128) → bg.
- Food at (4,2) under the body → BODY_COLOR. Move food to (0,0) with `food_valid`=1 → FOOD_COLOR at pixel (48,48). Pixel (47,48) → bg.
- Segment 1 = (10,3) on a 10×10 grid → `seg_error`=1 after COMMIT. The other segments draw normally. A clean frame → `seg_error`=0.
- `game_done`=1, BLINK_FRAMES=2: snake pixels are DEAD_COLOR for frames 0–1 and bg for frames 2–3, repeating.
- `reset` asserted during SCAN → IDLE, `color_out`=0 next cycle, snake absent until the next complete build. `active`=0 at any pixel → `color_out`=0.
